lsu_mem_ctrl: RTL

Load/store controller between the pipeline's MEM stage and the word-addressed data memory (64 x 32-bit words, synchronous write, combinational read gated by a read-enable). It accepts RV32I load/store requests (lb, lh, lw, lbu, lhu, sb, sh, sw) carrying byte addresses. Loads are sign- or zero-extended. Sub-word stores run as a two-cycle read-modify-write. Misaligned or invalid accesses are flagged.

---
 rtl/lsu_mem_ctrl_if.sv | 29 ++
 rtl/lsu_mem_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory bus between the MEM stage, lsu_mem_ctrl and the data memory.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rdata, rdata_valid, err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rdata, rdata_valid, err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller for a 64 x 32-bit word memory; sub-word stores use a
// two-cycle read-modify-write, misaligned or invalid accesses raise a one-cycle err.
module lsu_mem_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    lsu_mem_ctrl_if.slave   bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WADDR_W = 6;

    typedef enum logic [0:0] {IDLE, RMW_WR} state_t;

    state_t               state_q, state_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rmw_word_q, rmw_word_d;
    logic [WADDR_W-1:0]   rmw_addr_q, rmw_addr_d;

    logic                 req_ready_c, mem_read_c, mem_write_c;
    logic [WADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]    mem_wdata_c;
    logic                 ld_en, rmw_en, bad;
    logic [4:0]           shift;
    logic [DATA_W-1:0]    mask, ins;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;

    // Access decode: legality check and store lane mask, independent of memory data.
    always_comb begin
        bad   = 1'b1;
        shift = 5'd0;
        mask  = '0;
        case (bus.req_funct3)
            3'd0:    bad = 1'b0;
            3'd1:    bad = bus.req_addr[0];
            3'd2:    bad = (bus.req_addr[1:0] != 2'b00);
            3'd4:    bad = bus.req_write;
            3'd5:    bad = bus.req_write | bus.req_addr[0];
            default: bad = 1'b1;
        endcase
        if (bus.req_funct3[1:0] == 2'd1) begin
            shift = {bus.req_addr[1], 4'b0000};
            mask  = DATA_W'(32'h0000_FFFF) << shift;
        end else begin
            shift = {bus.req_addr[1:0], 3'b000};
            mask  = DATA_W'(32'h0000_00FF) << shift;
        end
        ins = (bus.req_wdata << shift) & mask;
    end

    // Control FSM; kept free of mem_rdata so the read enable never loops through memory.
    always_comb begin
        state_d       = state_q;
        req_ready_c   = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        mem_addr_c    = bus.req_addr[7:2];
        mem_wdata_c   = '0;
        ld_en         = 1'b0;
        rmw_en        = 1'b0;
        err_d         = 1'b0;
        rdata_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else if (!bus.req_write) begin
                        mem_read_c    = 1'b1;
                        ld_en         = 1'b1;
                        rdata_valid_d = 1'b1;
                    end else if (bus.req_funct3 == 3'd2) begin
                        mem_write_c = 1'b1;
                        mem_wdata_c = bus.req_wdata;
                    end else begin
                        mem_read_c = 1'b1;
                        rmw_en     = 1'b1;
                        state_d    = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_write_c = 1'b1;
                mem_addr_c  = rmw_addr_q;
                mem_wdata_c = rmw_word_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load extraction and sub-word merge from the combinational memory read.
    always_comb begin
        rdata_d    = rdata_q;
        rmw_word_d = rmw_word_q;
        rmw_addr_d = rmw_addr_q;
        ld_byte    = 8'(bus.mem_rdata >> {bus.req_addr[1:0], 3'b000});
        ld_half    = bus.req_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        if (ld_en) begin
            case (bus.req_funct3)
                3'd0:    rdata_d = {{24{ld_byte[7]}}, ld_byte};
                3'd1:    rdata_d = {{16{ld_half[15]}}, ld_half};
                3'd2:    rdata_d = bus.mem_rdata;
                3'd4:    rdata_d = {24'd0, ld_byte};
                default: rdata_d = {16'd0, ld_half};
            endcase
        end
        if (rmw_en) begin
            rmw_word_d = (bus.mem_rdata & ~mask) | ins;
            rmw_addr_d = bus.req_addr[7:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            rmw_word_q    <= '0;
            rmw_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
            rmw_word_q    <= rmw_word_d;
            rmw_addr_q    <= rmw_addr_d;
        end
    end

    // Reset gates the handshake and memory strobes immediately, aborting an in-flight write.
    assign bus.req_ready   = rst_n & req_ready_c;
    assign bus.mem_read    = rst_n & mem_read_c;
    assign bus.mem_write   = rst_n & mem_write_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.err         = err_q;
endmodule
